int_vec_seq: RTL and testbench
==============================

// Module: int_vec_seq
// PURPOSE
//  Interrupt/reset vector sequencer sitting directly upstream of the PC-low register.
//  Arbitrates RESET, NMI, IRQ and BRK at instruction boundaries.
//  Runs the stack-push and vector-fetch sequence.
//  Drives the PC-low preset strobes (setreset/setirq/setnmi), stack strobes and vector-read strobes.
// PARAMETERS
//  NMI_SYNC_STAGES  2  flop depth of the pin synchronizer (used only with INT_SYNC_EN)
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst_n        in   1  asynchronous active-low reset
//  nmi_n        in   1  NMI pin, falling-edge sensitive
//  irq_n        in   1  IRQ pin, level sensitive, active low
//  iflag        in   1  status I bit; 1 masks IRQ
//  brk          in   1  BRK opcode in execute, sampled with instr_done
//  instr_done   in   1  instruction-boundary pulse; the only point a sequence may start
//  mem_rdy      in   1  memory ready; 0 stalls push/vector states
//  busy         out  1  sequence in progress (blocks opcode fetch)
//  sp_dec       out  1  decrement stack pointer this cycle
//  push_pch     out  1  write PCH to stack
//  push_pcl     out  1  write PCL to stack
//  push_p       out  1  write status to stack
//  b_flag       out  1  B bit value for pushed status (1 only for BRK)
//  setreset     out  1  one-cycle preset of PC-low to FC
//  setnmi       out  1  one-cycle preset of PC-low to FA
//  setirq       out  1  one-cycle preset of PC-low to FE (IRQ and BRK)
//  set_iflag    out  1  set status I bit
//  vec_lo_rd    out  1  read vector low byte into PC-low
//  vec_hi_rd    out  1  read vector high byte into PC-high
//  seq_done     out  1  one-cycle pulse, sequence complete
// BEHAVIOUR
//  States: IDLE, S_PCH, S_PCL, S_P, S_SETV, S_VECL, S_VECH.
//  - Sequence order: S_PCH -> S_PCL -> S_P -> S_SETV -> S_VECL -> S_VECH -> IDLE.
//  Reset (rst_n low, any time, including mid-sequence):
//  - State is forced to S_PCH with src=RES, pending NMI cleared.
//  - All strobes are 0; busy=1. The reset sequence starts on the first clk after rst_n rises.
//  IDLE, on instr_done: priority RES > NMI pending > (IRQ: !irq_n & !iflag) > brk.
//  - Chosen source latched in src; next state S_PCH.
//  - No instr_done, or nothing pending: stay in IDLE.
//  S_PCH / S_PCL / S_P:
//  - sp_dec=1.
//  - push_* asserted only when src != RES; reset does dummy pushes with writes suppressed.
//  - b_flag=1 in S_P only when src=BRK.
//  - Strobes hold while mem_rdy=0; advance on mem_rdy=1.
//  S_SETV: single cycle, no stall.
//  - Source re-evaluated: if nmi_pend=1 and src is IRQ/BRK, src becomes NMI (hijack).
//  - Exactly one of setreset/setnmi/setirq pulsed; set_iflag=1.
//  - nmi_pend cleared if the NMI vector was used.
//  S_VECL: vec_lo_rd=1 (PC-low addresses vector lo); stalls on mem_rdy.
//  S_VECH: vec_hi_rd=1; stalls on mem_rdy. On advance: seq_done pulses and the next state is IDLE.
//  - busy is low only in IDLE.
//  NMI edge detect:
//  - A 1->0 transition of the nmi_n sample sets nmi_pend, in any state.
//  - An edge in the same cycle as a clear wins: nmi_pend stays 1.
//  IRQ is not latched: if irq_n is released before instr_done, it is lost.
//  brk is ignored unless instr_done=1. brk together with an IRQ-eligible request: IRQ taken, b_flag=0.
//  Outputs are combinational decodes of registered state/src only, with no input-to-output paths except the mem_rdy stall hold.
// CONFIGURATION
//  INT_SYNC_EN defined:
//  - nmi_n and irq_n pass through NMI_SYNC_STAGES flops (reset to 1) before use.
//  - NMI latency from pin edge to nmi_pend is NMI_SYNC_STAGES+1 cycles.
//  INT_SYNC_EN undefined:
//  - Pins are treated as synchronous; one sample flop for edge detect.
//  - NMI latency is 1 cycle.
// STRUCTURE
//  cpu_pkg:
//  - State encoding localparams (ST_IDLE..ST_VECH, 3 bits).
//  - Source encoding (SRC_RES=0, SRC_NMI=1, SRC_IRQ=2, SRC_BRK=3).
//  Sub-module int_pin_sync: synchronizer plus NMI falling-edge detector; the only place INT_SYNC_EN is tested.
//  Top level: arbitration, FSM, output decode.
// TESTING
//  - rst_n low 3 cycles, release, mem_rdy=1:
//    - sp_dec for 3 cycles with no push_*.
//    - setreset pulse on cycle 4, then vec_lo_rd, vec_hi_rd.
//    - seq_done on cycle 6, busy=0 after.
//  - irq_n=0, iflag=0, instr_done pulse:
//    - push_pch, push_pcl, push_p (b_flag=0), setirq+set_iflag, vector reads.
//    - Same with iflag=1: stays IDLE.
//  - brk=1 with instr_done: b_flag=1 in S_P, setirq pulse.
//    - brk=1 without instr_done: no sequence.
//  - IRQ sequence in S_PCL, nmi_n falls: setnmi (not setirq) in S_SETV, nmi_pend=0 after.
//    - A second NMI edge during S_VECL: new sequence at the next instr_done.
//  - mem_rdy=0 for 2 cycles in S_PCH and in S_VECL: strobes held, state frozen, total length +4 cycles.
//  - rst_n pulsed low during S_VECH of an NMI sequence:
//    - Outputs drop to 0 immediately, nmi_pend cleared.
//    - A full reset sequence follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the interrupt/reset vector sequencer.
// State and vector-source codes used by int_vec_seq and its bench.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PCH  = 3'd1,
        ST_PCL  = 3'd2,
        ST_P    = 3'd3,
        ST_SETV = 3'd4,
        ST_VECL = 3'd5,
        ST_VECH = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_e;

    localparam int NMI_SYNC_DEF = 2;

    function automatic logic is_maskable(input src_e s);
        return (s == SRC_IRQ) || (s == SRC_BRK);
    endfunction

endpackage

// File: rtl/int_pin_sync.sv
// Interrupt pin conditioning: optional synchronizer and NMI falling-edge detect.
// Build option INT_SYNC_EN adds STAGES-deep synchronizers on nmi_n and irq_n.
module int_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n_i,
    input  logic irq_n_i,
    output logic nmi_fall_o,
    output logic irq_n_o
);

`ifdef INT_SYNC_EN
    logic [STAGES-1:0] nmi_sync_q;
    logic [STAGES-1:0] irq_sync_q;
    logic              nmi_prev_q;
    logic              nmi_s;

    assign nmi_s = nmi_sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_sync_q <= (nmi_sync_q << 1) | STAGES'(nmi_n_i);
            irq_sync_q <= (irq_sync_q << 1) | STAGES'(irq_n_i);
            nmi_prev_q <= nmi_s;
        end
    end

    assign nmi_fall_o = nmi_prev_q & ~nmi_s;
    assign irq_n_o    = irq_sync_q[STAGES-1];
`else
    logic nmi_prev_q;
    logic unused_stages;

    // Pins are already synchronous here; only the edge sample remains.
    assign unused_stages = (STAGES > 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_prev_q <= nmi_n_i;
        end
    end

    assign nmi_fall_o = nmi_prev_q & ~nmi_n_i;
    assign irq_n_o    = irq_n_i;
`endif

endmodule

// File: rtl/int_vec_seq.sv
// Interrupt/reset vector sequencer: arbitration, push/vector FSM, strobe decode.
// Build option INT_SYNC_EN enables pin synchronizers inside int_pin_sync.
module int_vec_seq
    import cpu_pkg::*;
#(
    parameter int NMI_SYNC_STAGES = NMI_SYNC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    input  logic irq_n,
    input  logic iflag,
    input  logic brk,
    input  logic instr_done,
    input  logic mem_rdy,
    output logic busy,
    output logic sp_dec,
    output logic push_pch,
    output logic push_pcl,
    output logic push_p,
    output logic b_flag,
    output logic setreset,
    output logic setnmi,
    output logic setirq,
    output logic set_iflag,
    output logic vec_lo_rd,
    output logic vec_hi_rd,
    output logic seq_done
);

    state_e state_q, state_d;
    src_e   src_q, src_d;
    src_e   vec_src;
    logic   nmi_pend_q, nmi_pend_d;
    logic   nmi_clr;
    logic   nmi_fall;
    logic   irq_n_s;
    logic   irq_req;
    logic   push_en;

    int_pin_sync #(
        .STAGES (NMI_SYNC_STAGES)
    ) u_pin_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .nmi_n_i    (nmi_n),
        .irq_n_i    (irq_n),
        .nmi_fall_o (nmi_fall),
        .irq_n_o    (irq_n_s)
    );

    assign irq_req = ~irq_n_s & ~iflag;

    // A pending NMI steals the vector from an IRQ/BRK already pushing.
    assign vec_src = (nmi_pend_q && is_maskable(src_q)) ? SRC_NMI : src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PCH;
            src_q      <= SRC_RES;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        nmi_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_done) begin
                    if (nmi_pend_q) begin
                        src_d   = SRC_NMI;
                        state_d = ST_PCH;
                    end else if (irq_req) begin
                        src_d   = SRC_IRQ;
                        state_d = ST_PCH;
                    end else if (brk) begin
                        src_d   = SRC_BRK;
                        state_d = ST_PCH;
                    end
                end
            end
            ST_PCH: begin
                if (mem_rdy) state_d = ST_PCL;
            end
            ST_PCL: begin
                if (mem_rdy) state_d = ST_P;
            end
            ST_P: begin
                if (mem_rdy) state_d = ST_SETV;
            end
            ST_SETV: begin
                src_d   = vec_src;
                nmi_clr = (vec_src == SRC_NMI);
                state_d = ST_VECL;
            end
            ST_VECL: begin
                if (mem_rdy) state_d = ST_VECH;
            end
            ST_VECH: begin
                if (mem_rdy) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A fresh edge outranks the clear in the same cycle.
        nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
    end

    assign push_en = (src_q != SRC_RES);

    always_comb begin
        busy      = (state_q != ST_IDLE);
        sp_dec    = 1'b0;
        push_pch  = 1'b0;
        push_pcl  = 1'b0;
        push_p    = 1'b0;
        b_flag    = 1'b0;
        setreset  = 1'b0;
        setnmi    = 1'b0;
        setirq    = 1'b0;
        set_iflag = 1'b0;
        vec_lo_rd = 1'b0;
        vec_hi_rd = 1'b0;
        seq_done  = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_PCH: begin
                    sp_dec   = 1'b1;
                    push_pch = push_en;
                end
                ST_PCL: begin
                    sp_dec   = 1'b1;
                    push_pcl = push_en;
                end
                ST_P: begin
                    sp_dec = 1'b1;
                    push_p = push_en;
                    b_flag = (src_q == SRC_BRK);
                end
                ST_SETV: begin
                    set_iflag = 1'b1;
                    unique case (vec_src)
                        SRC_RES: setreset = 1'b1;
                        SRC_NMI: setnmi   = 1'b1;
                        default: setirq   = 1'b1;
                    endcase
                end
                ST_VECL: begin
                    vec_lo_rd = 1'b1;
                end
                ST_VECH: begin
                    vec_hi_rd = 1'b1;
                    seq_done  = mem_rdy;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_vec_seq.sv
// Directed bench for int_vec_seq: reset, IRQ, BRK, NMI hijack, stalls, mid-sequence reset.
// Output vector bits: busy sp pch pcl p b sr sn si sif vl vh done.
module tb_int_vec_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic nmi_n = 1'b1;
    logic irq_n = 1'b1;
    logic iflag = 1'b0;
    logic brk = 1'b0;
    logic instr_done = 1'b0;
    logic mem_rdy = 1'b1;
    logic busy, sp_dec, push_pch, push_pcl, push_p, b_flag;
    logic setreset, setnmi, setirq, set_iflag;
    logic vec_lo_rd, vec_hi_rd, seq_done;
    logic [12:0] outv;

    int checks = 0;
    int failures = 0;

    localparam logic [12:0] O_IDLE  = 13'b0000000000000;
    localparam logic [12:0] O_RST   = 13'b1000000000000;
    localparam logic [12:0] O_RPUSH = 13'b1100000000000;
    localparam logic [12:0] O_PCH   = 13'b1110000000000;
    localparam logic [12:0] O_PCL   = 13'b1101000000000;
    localparam logic [12:0] O_P     = 13'b1100100000000;
    localparam logic [12:0] O_PB    = 13'b1100110000000;
    localparam logic [12:0] O_SRES  = 13'b1000001001000;
    localparam logic [12:0] O_SNMI  = 13'b1000000101000;
    localparam logic [12:0] O_SIRQ  = 13'b1000000011000;
    localparam logic [12:0] O_VL    = 13'b1000000000100;
    localparam logic [12:0] O_VH    = 13'b1000000000011;

    int_vec_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nmi_n      (nmi_n),
        .irq_n      (irq_n),
        .iflag      (iflag),
        .brk        (brk),
        .instr_done (instr_done),
        .mem_rdy    (mem_rdy),
        .busy       (busy),
        .sp_dec     (sp_dec),
        .push_pch   (push_pch),
        .push_pcl   (push_pcl),
        .push_p     (push_p),
        .b_flag     (b_flag),
        .setreset   (setreset),
        .setnmi     (setnmi),
        .setirq     (setirq),
        .set_iflag  (set_iflag),
        .vec_lo_rd  (vec_lo_rd),
        .vec_hi_rd  (vec_hi_rd),
        .seq_done   (seq_done)
    );

    assign outv = {busy, sp_dec, push_pch, push_pcl, push_p, b_flag,
                   setreset, setnmi, setirq, set_iflag,
                   vec_lo_rd, vec_hi_rd, seq_done};

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        instr_done = 1'b1;
        nxt();
        instr_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] ev [7] = '{O_RPUSH, O_RPUSH, O_RPUSH, O_SRES,
                                O_VL, O_VH, O_IDLE};
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== O_RST) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, outv, O_RST);
            end
            nxt();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL reset_seq cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
    endtask

    task automatic test_irq();
        logic [12:0] ev [7] = '{O_PCH, O_PCL, O_P, O_SIRQ, O_VL, O_VH, O_IDLE};
        irq_n = 1'b0;
        kick();
        irq_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL irq_seq cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        iflag = 1'b1;
        irq_n = 1'b0;
        kick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== O_IDLE) begin
                failures++;
                $display("FAIL irq_masked cyc=%0d got=%b exp=%b", i, outv, O_IDLE);
            end
            nxt();
        end
        iflag = 1'b0;
        irq_n = 1'b1;
        nxt();
        kick();
        @(negedge clk);
        checks++;
        if (outv !== O_IDLE) begin
            failures++;
            $display("FAIL irq_lost got=%b exp=%b", outv, O_IDLE);
        end
        nxt();
    endtask

    task automatic test_brk();
        logic [12:0] ev [7] = '{O_PCH, O_PCL, O_PB, O_SIRQ, O_VL, O_VH, O_IDLE};
        logic [12:0] ei [7] = '{O_PCH, O_PCL, O_P, O_SIRQ, O_VL, O_VH, O_IDLE};
        brk = 1'b1;
        kick();
        brk = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL brk_seq cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        brk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== O_IDLE) begin
                failures++;
                $display("FAIL brk_no_done cyc=%0d got=%b exp=%b", i, outv, O_IDLE);
            end
            nxt();
        end
        irq_n = 1'b0;
        kick();
        brk = 1'b0;
        irq_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== ei[i]) begin
                failures++;
                $display("FAIL brk_irq cyc=%0d got=%b exp=%b", i, outv, ei[i]);
            end
            nxt();
        end
    endtask

    task automatic test_nmi_hijack();
        logic [12:0] ev [7] = '{O_PCH, O_PCL, O_P, O_SNMI, O_VL, O_VH, O_IDLE};
        irq_n = 1'b0;
        kick();
        irq_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) nmi_n = 1'b0;
            if (i == 2) nmi_n = 1'b1;
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL nmi_hijack cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        kick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== O_IDLE) begin
                failures++;
                $display("FAIL nmi_cleared cyc=%0d got=%b exp=%b", i, outv, O_IDLE);
            end
            nxt();
        end
    endtask

    task automatic test_nmi_repeat();
        logic [12:0] ev [7] = '{O_PCH, O_PCL, O_P, O_SNMI, O_VL, O_VH, O_IDLE};
        nmi_n = 1'b0;
        nxt();
        nmi_n = 1'b1;
        kick();
        for (int i = 0; i < 7; i++) begin
            if (i == 4) nmi_n = 1'b0;
            if (i == 5) nmi_n = 1'b1;
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL nmi_first cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        kick();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL nmi_second cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        kick();
        @(negedge clk);
        checks++;
        if (outv !== O_IDLE) begin
            failures++;
            $display("FAIL nmi_drained got=%b exp=%b", outv, O_IDLE);
        end
        nxt();
    endtask

    task automatic test_back_to_back_stall();
        logic [12:0] ev [11] = '{O_PCH, O_PCH, O_PCH, O_PCL, O_P, O_SIRQ,
                                 O_VL, O_VL, O_VL, O_VH, O_IDLE};
        logic rdy [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        irq_n = 1'b0;
        kick();
        irq_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            mem_rdy = rdy[i];
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        mem_rdy = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [12:0] ev [15] = '{O_PCH, O_PCL, O_P, O_SNMI, O_VL,
                                 O_RST, O_RST, O_RST,
                                 O_RPUSH, O_RPUSH, O_RPUSH, O_SRES,
                                 O_VL, O_VH, O_IDLE};
        nmi_n = 1'b0;
        nxt();
        nmi_n = 1'b1;
        kick();
        for (int i = 0; i < 15; i++) begin
            if (i == 4) nmi_n = 1'b0;
            if (i == 5) begin
                nmi_n = 1'b1;
                rst_n = 1'b0;
            end
            if (i == 8) rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (outv !== ev[i]) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, outv, ev[i]);
            end
            nxt();
        end
        kick();
        @(negedge clk);
        checks++;
        if (outv !== O_IDLE) begin
            failures++;
            $display("FAIL reset_mid_pend got=%b exp=%b", outv, O_IDLE);
        end
        nxt();
    endtask

    initial begin
        test_reset();
        test_irq();
        test_brk();
        test_nmi_hijack();
        test_nmi_repeat();
        test_back_to_back_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
